// File: rtl/riscv_core_mem_arbiter.sv
// Shares one memory port between I-cache refills, D-cache refills and D-cache
// write-through stores, one transaction at a time, and routes completion back.
module riscv_core_mem_arbiter #(
  parameter int ADDR_WIDTH      = 64,
  parameter int CORE_DATA_WIDTH = 64,
  parameter int AXI_DATA_WIDTH  = 256,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_ic_read_req,
  input  logic [ADDR_WIDTH-1:0]        i_ic_read_address,
  output logic                         o_ic_read_done,
  output logic [AXI_DATA_WIDTH-1:0]    o_ic_read_data,
  input  logic                         i_dc_read_req,
  input  logic [ADDR_WIDTH-1:0]        i_dc_read_address,
  output logic                         o_dc_read_done,
  output logic [AXI_DATA_WIDTH-1:0]    o_dc_read_data,
  input  logic                         i_dc_write_valid,
  input  logic [ADDR_WIDTH-1:0]        i_dc_write_address,
  input  logic [CORE_DATA_WIDTH-1:0]   i_dc_write_data,
  input  logic [CORE_DATA_WIDTH/8-1:0] i_dc_write_strobe,
  output logic                         o_dc_write_done,
  output logic                         o_mem_read_req,
  output logic [ADDR_WIDTH-1:0]        o_mem_read_address,
  input  logic                         i_mem_read_done,
  input  logic [AXI_DATA_WIDTH-1:0]    i_mem_read_data,
  output logic                         o_mem_write_valid,
  output logic [ADDR_WIDTH-1:0]        o_mem_write_address,
  output logic [CORE_DATA_WIDTH-1:0]   o_mem_write_data,
  output logic [CORE_DATA_WIDTH/8-1:0] o_mem_write_strobe,
  input  logic                         i_mem_write_done,
  output logic                         o_busy,
  output logic                         o_timeout_err,
  output logic [1:0]                   o_dbg_state
);

  // Handshake: every requester (upstream req/valid and our downstream
  // req/valid) holds its request with a stable command until the matching
  // one-cycle done; the transfer completes in the cycle done is high, and a
  // done with no matching outstanding request is ignored.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_IC = 2'd1,
    RD_DC = 2'd2,
    WR_DC = 2'd3
  } state_t;

  localparam logic       PTR_IC      = 1'b0;
  localparam logic       PTR_DC      = 1'b1;
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
  localparam logic       WD_ENABLE   = (TIMEOUT_CYCLES != 0);

  state_t      state_q, state_next;
  logic        rr_ptr_q;
  logic [15:0] wd_cnt_q, wd_cnt_next;
  logic        grant_ic, grant_dc, grant_wr;
  logic        ic_done, dc_done, wr_done;
  logic        wd_set;

  always_comb begin
    state_next  = state_q;
    grant_ic    = 1'b0;
    grant_dc    = 1'b0;
    grant_wr    = 1'b0;
    ic_done     = 1'b0;
    dc_done     = 1'b0;
    wr_done     = 1'b0;
    wd_cnt_next = 16'd0;
    wd_set      = 1'b0;
    case (state_q)
      IDLE: begin
        // Stores first, then round-robin between the two refill sources.
        if (i_dc_write_valid) begin
          grant_wr = 1'b1;
        end else if (i_ic_read_req && i_dc_read_req) begin
          grant_ic = (rr_ptr_q == PTR_IC);
          grant_dc = (rr_ptr_q == PTR_DC);
        end else begin
          grant_ic = i_ic_read_req;
          grant_dc = i_dc_read_req;
        end
        if (grant_wr)      state_next = WR_DC;
        else if (grant_ic) state_next = RD_IC;
        else if (grant_dc) state_next = RD_DC;
      end
      RD_IC: begin
        ic_done = i_mem_read_done;
        if (ic_done) state_next = IDLE;
      end
      RD_DC: begin
        dc_done = i_mem_read_done;
        if (dc_done) state_next = IDLE;
      end
      WR_DC: begin
        wr_done = i_mem_write_done;
        if (wr_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Counter equals the number of busy cycles including the current one.
    if (state_next != IDLE) begin
      wd_cnt_next = (wd_cnt_q == 16'hFFFF) ? wd_cnt_q : wd_cnt_q + 16'd1;
      wd_set      = WD_ENABLE && (wd_cnt_next == TIMEOUT_LIM);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q             <= IDLE;
      rr_ptr_q            <= PTR_IC;
      wd_cnt_q            <= 16'd0;
      o_timeout_err       <= 1'b0;
      o_busy              <= 1'b0;
      o_mem_read_req      <= 1'b0;
      o_mem_read_address  <= '0;
      o_mem_write_valid   <= 1'b0;
      o_mem_write_address <= '0;
      o_mem_write_data    <= '0;
      o_mem_write_strobe  <= '0;
    end else begin
      state_q  <= state_next;
      wd_cnt_q <= wd_cnt_next;
      if (wd_set) o_timeout_err <= 1'b1;
      if (grant_wr) begin
        o_mem_write_valid   <= 1'b1;
        o_mem_write_address <= i_dc_write_address;
        o_mem_write_data    <= i_dc_write_data;
        o_mem_write_strobe  <= i_dc_write_strobe;
        o_busy              <= 1'b1;
      end
      if (grant_ic || grant_dc) begin
        o_mem_read_req     <= 1'b1;
        o_mem_read_address <= grant_ic ? i_ic_read_address : i_dc_read_address;
        rr_ptr_q           <= grant_ic ? PTR_DC : PTR_IC;
        o_busy             <= 1'b1;
      end
      if (ic_done || dc_done) begin
        o_mem_read_req <= 1'b0;
        o_busy         <= 1'b0;
      end
      if (wr_done) begin
        o_mem_write_valid <= 1'b0;
        o_busy            <= 1'b0;
      end
    end
  end

  assign o_ic_read_done  = ic_done;
  assign o_dc_read_done  = dc_done;
  assign o_dc_write_done = wr_done;
  assign o_ic_read_data  = ic_done ? i_mem_read_data : '0;
  assign o_dc_read_data  = dc_done ? i_mem_read_data : '0;
  assign o_dbg_state     = state_q;

endmodule

// File: tb/tb_riscv_core_mem_arbiter.sv
// Directed bench for riscv_core_mem_arbiter: a per-cycle vector table for the
// arbitration/routing flows plus hand-written watchdog and reset sequences.
module tb_riscv_core_mem_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int LW = 256;

  logic          clk;
  logic          rst;
  logic          ic_req, dc_req, wr_v;
  logic [AW-1:0] ic_addr, dc_addr, wr_addr;
  logic [DW-1:0] wr_data;
  logic [7:0]    wr_strb;
  logic          m_rd_done, m_wr_done;
  logic [LW-1:0] m_rd_data;

  logic          ic_done_o, dc_done_o, wr_done_o;
  logic [LW-1:0] ic_data_o, dc_data_o;
  logic          rd_req_o, wr_v_o, busy_o, terr_o;
  logic [AW-1:0] rd_addr_o, wr_addr_o;
  logic [DW-1:0] wr_data_o;
  logic [7:0]    wr_strb_o;
  logic [1:0]    state_o;

  riscv_core_mem_arbiter #(
    .ADDR_WIDTH(AW), .CORE_DATA_WIDTH(DW), .AXI_DATA_WIDTH(LW), .TIMEOUT_CYCLES(8)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ic_read_req(ic_req), .i_ic_read_address(ic_addr),
    .o_ic_read_done(ic_done_o), .o_ic_read_data(ic_data_o),
    .i_dc_read_req(dc_req), .i_dc_read_address(dc_addr),
    .o_dc_read_done(dc_done_o), .o_dc_read_data(dc_data_o),
    .i_dc_write_valid(wr_v), .i_dc_write_address(wr_addr),
    .i_dc_write_data(wr_data), .i_dc_write_strobe(wr_strb),
    .o_dc_write_done(wr_done_o),
    .o_mem_read_req(rd_req_o), .o_mem_read_address(rd_addr_o),
    .i_mem_read_done(m_rd_done), .i_mem_read_data(m_rd_data),
    .o_mem_write_valid(wr_v_o), .o_mem_write_address(wr_addr_o),
    .o_mem_write_data(wr_data_o), .o_mem_write_strobe(wr_strb_o),
    .i_mem_write_done(m_wr_done),
    .o_busy(busy_o), .o_timeout_err(terr_o), .o_dbg_state(state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          ic_req;
    logic [AW-1:0] ic_addr;
    logic          dc_req;
    logic [AW-1:0] dc_addr;
    logic          wr_v;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [7:0]    wr_strb;
    logic          m_rd_done;
    logic [LW-1:0] m_rd_data;
    logic          m_wr_done;
    logic [1:0]    e_state;
    logic          e_busy;
    logic          e_rd_req;
    logic [AW-1:0] e_rd_addr;
    logic          e_wr_v;
    logic [AW-1:0] e_wr_addr;
    logic [DW-1:0] e_wr_data;
    logic [7:0]    e_wr_strb;
    logic          e_ic_done;
    logic          e_dc_done;
    logic          e_wr_done;
    logic [LW-1:0] e_data;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  logic [LW-1:0] d1, d2, d3, d4, d5;
  localparam logic [DW-1:0] WD1 = 64'h1122334455667788;
  localparam logic [DW-1:0] WD2 = 64'hCAFEF00D12345678;

  function automatic vec_t blank();
    vec_t v;
    v = '{default: '0};
    return v;
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver
  task automatic apply(input vec_t v);
    rst = v.rst; ic_req = v.ic_req; ic_addr = v.ic_addr;
    dc_req = v.dc_req; dc_addr = v.dc_addr;
    wr_v = v.wr_v; wr_addr = v.wr_addr; wr_data = v.wr_data; wr_strb = v.wr_strb;
    m_rd_done = v.m_rd_done; m_rd_data = v.m_rd_data; m_wr_done = v.m_wr_done;
  endtask

  task automatic check_row(input int r, input vec_t v);
    string p;
    p = $sformatf("row%0d", r);
    chk({p, ".state"}, LW'(state_o), LW'(v.e_state));
    chk({p, ".busy"}, LW'(busy_o), LW'(v.e_busy));
    chk({p, ".rd_req"}, LW'(rd_req_o), LW'(v.e_rd_req));
    chk({p, ".wr_valid"}, LW'(wr_v_o), LW'(v.e_wr_v));
    chk({p, ".ic_done"}, LW'(ic_done_o), LW'(v.e_ic_done));
    chk({p, ".dc_done"}, LW'(dc_done_o), LW'(v.e_dc_done));
    chk({p, ".wr_done"}, LW'(wr_done_o), LW'(v.e_wr_done));
    chk({p, ".timeout_err"}, LW'(terr_o), '0);
    if (v.e_rd_req) chk({p, ".rd_addr"}, LW'(rd_addr_o), LW'(v.e_rd_addr));
    if (v.e_wr_v) begin
      chk({p, ".wr_addr"}, LW'(wr_addr_o), LW'(v.e_wr_addr));
      chk({p, ".wr_data"}, LW'(wr_data_o), LW'(v.e_wr_data));
      chk({p, ".wr_strb"}, LW'(wr_strb_o), LW'(v.e_wr_strb));
    end
    if (v.e_ic_done) chk({p, ".ic_data"}, ic_data_o, v.e_data);
    if (v.e_dc_done) chk({p, ".dc_data"}, dc_data_o, v.e_data);
  endtask

  task automatic build_table();
    vec_t v;
    // IC read alone
    v = blank(); vecs.push_back(v);
    v = blank(); v.ic_req = 1; v.ic_addr = 'h1000; vecs.push_back(v);
    v.e_state = 1; v.e_busy = 1; v.e_rd_req = 1; v.e_rd_addr = 'h1000; vecs.push_back(v);
    v.m_rd_done = 1; v.m_rd_data = d1; v.e_ic_done = 1; v.e_data = d1; vecs.push_back(v);
    v = blank(); vecs.push_back(v);
    // reset returns rr_ptr to IC
    v = blank(); v.rst = 1; vecs.push_back(v);
    // both reads: IC, DC, IC, DC
    v = blank(); v.ic_req = 1; v.ic_addr = 'h100; v.dc_req = 1; v.dc_addr = 'h200; vecs.push_back(v);
    v.e_state = 1; v.e_busy = 1; v.e_rd_req = 1; v.e_rd_addr = 'h100; vecs.push_back(v);
    v.m_rd_done = 1; v.m_rd_data = d2; v.e_ic_done = 1; v.e_data = d2; vecs.push_back(v);
    v = blank(); v.ic_req = 1; v.ic_addr = 'h140; v.dc_req = 1; v.dc_addr = 'h200; vecs.push_back(v);
    v.e_state = 2; v.e_busy = 1; v.e_rd_req = 1; v.e_rd_addr = 'h200; vecs.push_back(v);
    v.m_rd_done = 1; v.m_rd_data = d3; v.e_dc_done = 1; v.e_data = d3; vecs.push_back(v);
    v = blank(); v.ic_req = 1; v.ic_addr = 'h140; v.dc_req = 1; v.dc_addr = 'h240; vecs.push_back(v);
    v.e_state = 1; v.e_busy = 1; v.e_rd_req = 1; v.e_rd_addr = 'h140; vecs.push_back(v);
    v.m_rd_done = 1; v.m_rd_data = d4; v.e_ic_done = 1; v.e_data = d4; vecs.push_back(v);
    v = blank(); v.dc_req = 1; v.dc_addr = 'h240; vecs.push_back(v);
    // write done during a DC read is ignored
    v.m_wr_done = 1; v.e_state = 2; v.e_busy = 1; v.e_rd_req = 1; v.e_rd_addr = 'h240; vecs.push_back(v);
    vecs.push_back(v);
    v.m_wr_done = 0; v.m_rd_done = 1; v.m_rd_data = d5; v.e_dc_done = 1; v.e_data = d5; vecs.push_back(v);
    v = blank(); vecs.push_back(v);
    // store beats a pending IC read; stray read done in IDLE/WR_DC ignored
    v = blank(); v.wr_v = 1; v.wr_addr = 'h2008; v.wr_data = WD1; v.wr_strb = 8'hFF;
    v.ic_req = 1; v.ic_addr = 'h3000; v.m_rd_done = 1; v.m_rd_data = d1; vecs.push_back(v);
    v.e_state = 3; v.e_busy = 1; v.e_wr_v = 1; v.e_wr_addr = 'h2008; v.e_wr_data = WD1;
    v.e_wr_strb = 8'hFF; vecs.push_back(v);
    v.m_rd_done = 0; v.m_wr_done = 1; v.e_wr_done = 1; vecs.push_back(v);
    v = blank(); v.ic_req = 1; v.ic_addr = 'h3000; vecs.push_back(v);
    v.e_state = 1; v.e_busy = 1; v.e_rd_req = 1; v.e_rd_addr = 'h3000; vecs.push_back(v);
    // requester drops its request; the read still completes
    v.ic_req = 0; v.m_rd_done = 1; v.m_rd_data = d2; v.e_ic_done = 1; v.e_data = d2; vecs.push_back(v);
    v = blank(); vecs.push_back(v);
    // reset in WR_DC; the late write done is ignored
    v = blank(); v.wr_v = 1; v.wr_addr = 'h4000; v.wr_data = WD2; v.wr_strb = 8'h0F; vecs.push_back(v);
    v.rst = 1; v.e_state = 3; v.e_busy = 1; v.e_wr_v = 1; v.e_wr_addr = 'h4000;
    v.e_wr_data = WD2; v.e_wr_strb = 8'h0F; vecs.push_back(v);
    v = blank(); v.m_wr_done = 1; vecs.push_back(v);
    v = blank(); vecs.push_back(v);
  endtask

  initial begin
    d1 = {8{32'hA5A5A5A5}};
    d2 = {4{64'h0123456789ABCDEF}};
    d3 = {32{8'h3C}};
    d4 = {8{32'hDEADBEEF}};
    d5 = {16{16'h5A5A}};
    apply(blank());
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    // reset state
    chk("reset.state", LW'(state_o), '0);
    chk("reset.busy", LW'(busy_o), '0);
    chk("reset.rd_req", LW'(rd_req_o), '0);
    chk("reset.rd_addr", LW'(rd_addr_o), '0);
    chk("reset.wr_valid", LW'(wr_v_o), '0);
    chk("reset.wr_addr", LW'(wr_addr_o), '0);
    chk("reset.wr_data", LW'(wr_data_o), '0);
    chk("reset.wr_strb", LW'(wr_strb_o), '0);
    chk("reset.timeout_err", LW'(terr_o), '0);

    build_table();
    for (int r = 0; r < vecs.size(); r++) begin
      @(negedge clk);
      apply(vecs[r]);
      #1;
      check_row(r, vecs[r]);
    end

    // watchdog: memory never answers an IC read
    @(negedge clk);
    apply(blank());
    ic_req = 1'b1; ic_addr = 'h5000;
    #1;
    chk("wd.grant_cycle_err", LW'(terr_o), '0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("wd.busy%0d.err", k), LW'(terr_o), LW'(k >= 8));
      chk($sformatf("wd.busy%0d.state", k), LW'(state_o), LW'(2'd1));
      chk($sformatf("wd.busy%0d.rd_req", k), LW'(rd_req_o), LW'(1'b1));
    end
    @(negedge clk);
    rst = 1'b1; ic_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("wd.after_rst.err", LW'(terr_o), '0);
    chk("wd.after_rst.busy", LW'(busy_o), '0);
    chk("wd.after_rst.rd_req", LW'(rd_req_o), '0);
    m_rd_done = 1'b1; m_rd_data = d3;
    #1;
    chk("wd.late_done.ic_done", LW'(ic_done_o), '0);
    @(negedge clk);
    m_rd_done = 1'b0;

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
